piece_dropper: RTL and testbench

- Gravity stage directly downstream of Piece_Placer: takes the four grid addresses of the freshly placed active piece and moves the piece down one row per step request.
- Checks occupancy through the Grid_Mem read port (b); drives the Grid_Mem write port (a) to erase and redraw the piece; reports when the piece can no longer fall.
- The top level muxes port a between placer and dropper. Placer en and dropper step are never active together (top-level guarantee).

---
 rtl/piece_dropper.sv | 248 ++++++++++++++++++++++++
 tb/tb_piece_dropper.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_dropper.sv
// ---------------------------------------------------------------------------
// piece_dropper
//
// Gravity stage for the falling piece. It holds the four grid addresses of the
// active piece. On each accepted step request it does four things in order:
//   1. It reads the four cells one row below the piece through Grid_Mem port b.
//   2. It decides whether the piece can fall.
//   3. If it can fall, it erases the piece and redraws it one row lower
//      through Grid_Mem port a.
//   4. It pulses done.
// If the piece cannot fall, it raises the sticky landed flag and does no
// writes.
//
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   load                      one-cycle pulse, captures blk_in_1..4 and colour
//   blk_in_1..blk_in_4        block addresses from the placer
//   piece_color               value written into each block cell
//   step                      one-cycle request to fall by one row (IDLE only)
//   rd_addr / rd_data         Grid_Mem port b (data valid one cycle later)
//   we / wr_addr / wr_data    Grid_Mem port a
//   busy                      high while a step is being processed
//   done                      one-cycle pulse at the end of every accepted step
//   landed                    sticky, the piece can no longer fall
//   blk_out_1..blk_out_4      current block addresses
// ---------------------------------------------------------------------------
module piece_dropper #(
    parameter int GRID_W     = 12,
    parameter int GRID_CELLS = 240,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] blk_in_1,
    input  logic [ADDR_W-1:0] blk_in_2,
    input  logic [ADDR_W-1:0] blk_in_3,
    input  logic [ADDR_W-1:0] blk_in_4,
    input  logic [DATA_W-1:0] piece_color,
    input  logic              step,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              landed,
    output logic [ADDR_W-1:0] blk_out_1,
    output logic [ADDR_W-1:0] blk_out_2,
    output logic [ADDR_W-1:0] blk_out_3,
    output logic [ADDR_W-1:0] blk_out_4
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ERASE,
        S_WRITE,
        S_DONE
    } state_t;

    // The target sum is one bit wider so that an address near the top of the
    // address space cannot wrap back into the playfield.
    localparam logic [ADDR_W:0] TGT_STEP  = (ADDR_W+1)'(GRID_W);
    localparam logic [ADDR_W:0] TGT_LIMIT = (ADDR_W+1)'(GRID_CELLS);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              blocked_q, blocked_d;
    logic              landed_q, landed_d;
    logic [ADDR_W-1:0] blk_q [4];
    logic [ADDR_W-1:0] blk_d [4];
    logic [DATA_W-1:0] color_q, color_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [ADDR_W:0]   tgt      [4];
    logic [ADDR_W-1:0] tgt_addr [4];
    logic [ADDR_W-1:0] tgt_rd   [4];
    logic [3:0]        tgt_oob;
    logic [3:0]        tgt_self;

    logic [1:0]        sample_idx;
    logic [1:0]        next_idx;
    logic              cell_hit;
    logic              blocked_now;

    // Target of each block one row down. A target that lands on another cell
    // of the same piece is "self". That cell is vacated by the move, so its
    // memory contents must not block the fall.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tgt[i]      = {1'b0, blk_q[i]} + TGT_STEP;
            tgt_oob[i]  = (tgt[i] >= TGT_LIMIT);
            tgt_addr[i] = tgt[i][ADDR_W-1:0];
            tgt_rd[i]   = tgt_oob[i] ? '0 : tgt_addr[i];
            tgt_self[i] = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (tgt[i] == {1'b0, blk_q[j]}) begin
                    tgt_self[i] = 1'b1;
                end
            end
        end
    end

    // Sequencer.
    //
    // The counter indexes the sub-cycle within CHECK, ERASE and WRITE. The
    // read and write address registers are loaded on the edge that enters a
    // sub-cycle, so each address is already valid during the cycle that uses
    // it.
    //
    // In CHECK, the read for block n comes back one cycle after its address.
    // Therefore K1..K4 sample blocks 1..4.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blocked_d   = blocked_q;
        landed_d    = landed_q;
        blk_d       = blk_q;
        color_d     = color_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        sample_idx  = cnt_q[1:0] - 2'd1;
        next_idx    = cnt_q[1:0] + 2'd1;
        cell_hit    = 1'b0;
        blocked_now = blocked_q;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    blk_d[0] = blk_in_1;
                    blk_d[1] = blk_in_2;
                    blk_d[2] = blk_in_3;
                    blk_d[3] = blk_in_4;
                    color_d  = piece_color;
                    landed_d = 1'b0;
                end else if (step && !landed_q) begin
                    state_d   = S_CHECK;
                    cnt_d     = 3'd0;
                    blocked_d = 1'b0;
                    rd_addr_d = tgt_rd[0];
                end
            end

            S_CHECK: begin
                if (cnt_q != 3'd0) begin
                    cell_hit = tgt_oob[sample_idx] ||
                               (!tgt_self[sample_idx] && (rd_data != '0));
                end
                blocked_now = blocked_q | cell_hit;
                blocked_d   = blocked_now;
                if (cnt_q < 3'd3) begin
                    rd_addr_d = tgt_rd[next_idx];
                end
                if (cnt_q == 3'd4) begin
                    if (blocked_now) begin
                        state_d  = S_DONE;
                        landed_d = 1'b1;
                    end else begin
                        state_d   = S_ERASE;
                        cnt_d     = 3'd0;
                        wr_addr_d = blk_q[0];
                        wr_data_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            // All old cells are cleared before any new cell is drawn. This
            // matters because old and new positions overlap.
            S_ERASE: begin
                if (cnt_q[1:0] != 2'd3) begin
                    wr_addr_d = blk_q[next_idx];
                    cnt_d     = cnt_q + 3'd1;
                end else begin
                    state_d   = S_WRITE;
                    cnt_d     = 3'd0;
                    wr_addr_d = tgt_addr[0];
                    wr_data_d = color_q;
                end
            end

            S_WRITE: begin
                if (cnt_q[1:0] != 2'd3) begin
                    wr_addr_d = tgt_addr[next_idx];
                    cnt_d     = cnt_q + 3'd1;
                end else begin
                    state_d = S_DONE;
                    blk_d   = tgt_addr;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            blocked_q <= 1'b0;
            landed_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                blk_q[i] <= '0;
            end
            color_q   <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
            landed_q  <= landed_d;
            blk_q     <= blk_d;
            color_q   <= color_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign we        = (state_q == S_ERASE) || (state_q == S_WRITE);
    assign landed    = landed_q;
    assign rd_addr   = rd_addr_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign blk_out_1 = blk_q[0];
    assign blk_out_2 = blk_q[1];
    assign blk_out_3 = blk_q[2];
    assign blk_out_4 = blk_q[3];

endmodule

// File: tb/tb_piece_dropper.sv
// ---------------------------------------------------------------------------
// tb_piece_dropper
//
// Exercises piece_dropper against a small Grid_Mem model and a cell-level
// reference of the playfield. The reference applies the gravity rules
// directly to a plain array:
//   - Each block's target is one row lower.
//   - A target is blocked if it is off the field, or if it is occupied by a
//     cell that is not part of the piece.
//   - Otherwise the piece moves.
// The bench runs the directed scenarios first, then random pieces dropped
// onto random debris.
// ---------------------------------------------------------------------------
module tb_piece_dropper;

    localparam int GRID_W     = 12;
    localparam int GRID_CELLS = 240;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic              step;
    logic [ADDR_W-1:0] blk_in [4];
    logic [DATA_W-1:0] piece_color;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              landed;
    logic [ADDR_W-1:0] blk_out [4];

    // Grid_Mem model: registered read on port b, write on port a. The bench
    // can also clear the whole array or poke one cell while the DUT is idle.
    logic [DATA_W-1:0] mem [256];
    logic              mem_clear;
    logic              tb_we;
    logic [ADDR_W-1:0] tb_addr;
    logic [DATA_W-1:0] tb_data;

    // Reference state.
    int ref_grid [256];
    int ref_blk  [4];
    int ref_color;
    int ref_landed;
    int exp_lat;
    int exp_we;
    int exp_rd   [4];

    int off_r [4];
    int off_c [4];

    int error_count = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    piece_dropper #(
        .GRID_W    (GRID_W),
        .GRID_CELLS(GRID_CELLS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .blk_in_1   (blk_in[0]),
        .blk_in_2   (blk_in[1]),
        .blk_in_3   (blk_in[2]),
        .blk_in_4   (blk_in[3]),
        .piece_color(piece_color),
        .step       (step),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .landed     (landed),
        .blk_out_1  (blk_out[0]),
        .blk_out_2  (blk_out[1]),
        .blk_out_3  (blk_out[2]),
        .blk_out_4  (blk_out[3])
    );

    // Grid_Mem behaviour: one-cycle read latency, write on the rising edge.
    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= '0;
            end
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Safety net in case something stalls outside the bounded loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time expired, required finish");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point. It counts the check and reports any
    // difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, required %0d", tag, observed, expected);
        end
    endtask

    // Drives load/step for exactly one rising edge and returns #1 after that
    // edge. The edge in the middle is the sampling edge.
    task automatic applyStimulus(input logic do_load, input logic do_step,
                                 input int a0, input int a1, input int a2,
                                 input int a3, input int col);
        @(posedge clk);
        #1;
        load        = do_load;
        step        = do_step;
        blk_in[0]   = a0[ADDR_W-1:0];
        blk_in[1]   = a1[ADDR_W-1:0];
        blk_in[2]   = a2[ADDR_W-1:0];
        blk_in[3]   = a3[ADDR_W-1:0];
        piece_color = col[DATA_W-1:0];
        @(posedge clk);
        #1;
        load = 1'b0;
        step = 1'b0;
    endtask

    task automatic memClear();
        @(posedge clk);
        #1;
        mem_clear = 1'b1;
        @(posedge clk);
        #1;
        mem_clear = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref_grid[i] = 0;
        end
    endtask

    task automatic memPoke(input int addr, input int data);
        @(posedge clk);
        #1;
        tb_we   = 1'b1;
        tb_addr = addr[ADDR_W-1:0];
        tb_data = data[DATA_W-1:0];
        @(posedge clk);
        #1;
        tb_we = 1'b0;
        ref_grid[addr] = data;
    endtask

    // Draws the piece into memory as the placer would, then loads it.
    task automatic placePiece(input int a0, input int a1, input int a2,
                              input int a3, input int col);
        memPoke(a0, col);
        memPoke(a1, col);
        memPoke(a2, col);
        memPoke(a3, col);
        applyStimulus(1'b1, 1'b0, a0, a1, a2, a3, col);
        ref_blk[0] = a0;
        ref_blk[1] = a1;
        ref_blk[2] = a2;
        ref_blk[3] = a3;
        ref_color  = col;
        ref_landed = 0;
    endtask

    // Gravity rule applied to the reference playfield.
    task automatic refStep();
        int t [4];
        int blocked;
        int is_self;
        exp_lat = 0;
        exp_we  = 0;
        for (int i = 0; i < 4; i++) begin
            t[i]      = ref_blk[i] + GRID_W;
            exp_rd[i] = (t[i] < GRID_CELLS) ? t[i] : 0;
        end
        if (ref_landed != 0) begin
            return;
        end
        blocked = 0;
        for (int i = 0; i < 4; i++) begin
            is_self = 0;
            for (int j = 0; j < 4; j++) begin
                if (t[i] == ref_blk[j]) begin
                    is_self = 1;
                end
            end
            if (t[i] >= GRID_CELLS) begin
                blocked = 1;
            end else if (is_self == 0 && ref_grid[t[i]] != 0) begin
                blocked = 1;
            end
        end
        if (blocked != 0) begin
            ref_landed = 1;
            exp_lat    = 6;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ref_grid[ref_blk[i]] = 0;
            end
            for (int i = 0; i < 4; i++) begin
                ref_grid[t[i]] = ref_color;
                ref_blk[i]     = t[i];
            end
            exp_lat = 14;
            exp_we  = 8;
        end
    endtask

    task automatic checkMem(input string tag);
        int diffs;
        int first;
        diffs = 0;
        first = -1;
        for (int i = 0; i < 256; i++) begin
            if (int'(mem[i]) != ref_grid[i]) begin
                diffs++;
                if (first < 0) begin
                    first = i;
                end
            end
        end
        if (diffs != 0) begin
            $display("[TB] note %s: first differing cell %0d holds %0d, model %0d",
                     tag, first, mem[first], ref_grid[first]);
        end
        checkOutput({tag, "_memDiffs"}, diffs, 0);
    endtask

    task automatic checkPiece(input string tag);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_blk%0d", tag, i + 1), blk_out[i], ref_blk[i]);
        end
        checkOutput({tag, "_landed"}, landed, ref_landed);
        checkOutput({tag, "_busyIdle"}, busy, 0);
        checkMem(tag);
    endtask

    // One step request. It tracks the done latency, the number of write
    // cycles and the first four read addresses. If inject_load is set, a
    // load pulse with unrelated addresses is applied while the DUT is busy.
    task automatic doStep(input string tag, input bit inject_load);
        int lat;
        int we_cnt;
        int busy_seen;
        int obs_rd [4];
        int limit;
        refStep();
        lat       = 0;
        we_cnt    = 0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            obs_rd[i] = -1;
        end
        limit = (exp_lat == 0) ? 20 : 30;
        applyStimulus(1'b0, 1'b1, 0, 0, 0, 0, 0);
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            if (cyc <= 4) begin
                obs_rd[cyc-1] = int'(rd_addr);
            end
            if (we) begin
                we_cnt++;
            end
            if (busy) begin
                busy_seen = 1;
            end
            if (inject_load && cyc == 3) begin
                load      = 1'b1;
                blk_in[0] = 8'd100;
                blk_in[1] = 8'd101;
                blk_in[2] = 8'd102;
                blk_in[3] = 8'd103;
            end
            if (cyc == 4) begin
                load = 1'b0;
            end
            if (done && lat == 0) begin
                lat = cyc;
                break;
            end
        end
        load = 1'b0;
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_weCycles"}, we_cnt, exp_we);
        if (exp_lat != 0) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("%s_rd%0d", tag, i + 1), obs_rd[i], exp_rd[i]);
            end
        end else begin
            checkOutput({tag, "_busyIgnored"}, busy_seen, 0);
        end
        @(negedge clk);
        checkOutput({tag, "_doneAfter"}, done, 0);
        checkPiece(tag);
    endtask

    task automatic pickShape(input int s);
        case (s)
            0: begin off_r = '{0, 1, 2, 3}; off_c = '{0, 0, 0, 0}; end
            1: begin off_r = '{0, 0, 1, 1}; off_c = '{0, 1, 0, 1}; end
            2: begin off_r = '{0, 0, 0, 1}; off_c = '{0, 1, 2, 1}; end
            3: begin off_r = '{0, 1, 2, 2}; off_c = '{0, 0, 0, 1}; end
            4: begin off_r = '{0, 1, 2, 2}; off_c = '{1, 1, 1, 0}; end
            5: begin off_r = '{0, 0, 1, 1}; off_c = '{1, 2, 0, 1}; end
            default: begin off_r = '{0, 0, 1, 1}; off_c = '{0, 1, 1, 2}; end
        endcase
    endtask

    initial begin
        int cells [4];
        int row;
        int col;
        int colour;

        rst         = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        mem_clear   = 1'b0;
        tb_we       = 1'b0;
        tb_addr     = '0;
        tb_data     = '0;
        piece_color = '0;
        for (int i = 0; i < 4; i++) begin
            blk_in[i]  = '0;
            ref_blk[i] = 0;
        end
        ref_color  = 0;
        ref_landed = 0;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_landed", landed, 0);
        checkOutput("rst_we", we, 0);
        checkOutput("rst_rdAddr", rd_addr, 0);
        checkOutput("rst_wrAddr", wr_addr, 0);
        checkOutput("rst_wrData", wr_data, 0);
        checkOutput("rst_blk1", blk_out[0], 0);
        rst = 1'b1;
        memClear();

        // Vertical I falls one row.
        placePiece(5, 17, 29, 41, 3);
        doStep("iFall", 1'b0);
        checkOutput("iFall_mem5", mem[5], 0);
        checkOutput("iFall_mem53", mem[53], 3);

        // Bottom-row piece lands because its targets are off the field.
        memClear();
        placePiece(216, 228, 229, 230, 4);
        doStep("floor", 1'b0);

        // Landing on debris, then an ignored step.
        memClear();
        memPoke(53, 7);
        placePiece(5, 17, 29, 41, 3);
        doStep("debris", 1'b0);
        checkOutput("debris_mem5", mem[5], 3);
        checkOutput("debris_mem53", mem[53], 7);
        doStep("ignored", 1'b0);

        // O piece falls three rows. A load during busy must not disturb it.
        memClear();
        placePiece(4, 5, 16, 17, 2);
        doStep("o1", 1'b1);
        doStep("o2", 1'b0);
        doStep("o3", 1'b1);
        checkOutput("o3_blk1", blk_out[0], 40);
        checkOutput("o3_blk4", blk_out[3], 53);

        // Asynchronous reset during the second ERASE cycle. Only the first
        // erase write has reached memory at that point.
        memClear();
        placePiece(5, 17, 29, 41, 3);
        applyStimulus(1'b0, 1'b1, 0, 0, 0, 0, 0);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_we", we, 0);
        checkOutput("arst_wrAddr", wr_addr, 0);
        checkOutput("arst_rdAddr", rd_addr, 0);
        checkOutput("arst_blk1", blk_out[0], 0);
        checkOutput("arst_blk4", blk_out[3], 0);
        ref_grid[5] = 0;
        for (int i = 0; i < 4; i++) begin
            ref_blk[i] = 0;
        end
        ref_landed = 0;
        ref_color  = 0;
        @(negedge clk);
        rst = 1'b1;
        checkMem("arst");
        memClear();
        placePiece(6, 18, 30, 42, 5);
        doStep("postRst", 1'b0);

        // load and step in the same cycle: load wins and no step starts.
        memClear();
        memPoke(7, 6);
        memPoke(8, 6);
        memPoke(9, 6);
        memPoke(20, 6);
        applyStimulus(1'b1, 1'b1, 7, 8, 9, 20, 6);
        ref_blk    = '{7, 8, 9, 20};
        ref_color  = 6;
        ref_landed = 0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("ldStep_busy", busy, 0);
        end
        checkPiece("ldStep");
        doStep("ldStepNext", 1'b0);

        // Random pieces dropped onto random debris until they land.
        for (int p = 0; p < 8; p++) begin
            memClear();
            for (int k = 0; k < 14; k++) begin
                memPoke(96 + $urandom_range(0, 143), $urandom_range(1, 255));
            end
            pickShape($urandom_range(0, 6));
            row    = $urandom_range(0, 2);
            col    = $urandom_range(0, 9);
            colour = $urandom_range(1, 255);
            for (int i = 0; i < 4; i++) begin
                cells[i] = (row + off_r[i]) * GRID_W + col + off_c[i];
            end
            placePiece(cells[0], cells[1], cells[2], cells[3], colour);
            for (int s = 0; s < 22 && ref_landed == 0; s++) begin
                doStep($sformatf("rnd%0d_s%0d", p, s), ($urandom_range(0, 3) == 0));
            end
            doStep($sformatf("rnd%0d_after", p), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
